// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared note codes, FSM states and ROM entry layout for melody_sequencer
package melody_pkg;

    typedef enum logic [2:0] {
        DO    = 3'd0,
        RE    = 3'd1,
        MI    = 3'd2,
        FA    = 3'd3,
        SOL   = 3'd4,
        LA    = 3'd5,
        TI    = 3'd6,
        DO_HI = 3'd7
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int REST_BIT = 7;
    localparam int NOTE_MSB = 6;
    localparam int NOTE_LSB = 4;
    localparam int DUR_MSB  = 3;
    localparam int DUR_LSB  = 0;

    localparam logic [3:0] END_MARK = 4'd0;

    function automatic logic [3:0] entry_dur(input logic [7:0] e);
        return e[DUR_MSB:DUR_LSB];
    endfunction

    function automatic logic [2:0] entry_note(input logic [7:0] e);
        return e[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic entry_rest(input logic [7:0] e);
        return e[REST_BIT];
    endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational melody table; MELODY_LOOP_EN selects a full 16-entry looping tune
module melody_rom #(
    parameter int LEN = 16,
    parameter int AW  = 4
) (
    input  logic [AW-1:0] addr,
    output logic [7:0]    data
);
    import melody_pkg::*;

    always_comb begin
        data = {1'b0, DO, END_MARK};
        case (addr)
`ifdef MELODY_LOOP_EN
            AW'(0):  data = {1'b0, LA,    4'd1};
            AW'(1):  data = {1'b0, DO,    4'd1};
            AW'(2):  data = {1'b0, RE,    4'd1};
            AW'(3):  data = {1'b0, MI,    4'd1};
            AW'(4):  data = {1'b0, FA,    4'd1};
            AW'(5):  data = {1'b0, SOL,   4'd1};
            AW'(6):  data = {1'b0, LA,    4'd1};
            AW'(7):  data = {1'b0, TI,    4'd1};
            AW'(8):  data = {1'b0, DO_HI, 4'd1};
            AW'(9):  data = {1'b0, TI,    4'd1};
            AW'(10): data = {1'b0, LA,    4'd1};
            AW'(11): data = {1'b0, SOL,   4'd1};
            AW'(12): data = {1'b0, FA,    4'd1};
            AW'(13): data = {1'b0, MI,    4'd1};
            AW'(14): data = {1'b0, RE,    4'd1};
            AW'(15): data = {1'b0, DO,    4'd1};
`else
            AW'(0):  data = {1'b0, LA,    4'd3};
            AW'(1):  data = {1'b1, MI,    4'd1};
            AW'(2):  data = {1'b0, DO,    END_MARK};
            // Past the end marker; never reached while the marker is in place.
            AW'(3):  data = {1'b0, DO_HI, 4'd4};
`endif
            default: data = {1'b0, DO, END_MARK};
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - ROM-driven note sequencer for a piezo controller; MELODY_LOOP_EN enables looped playback
module melody_sequencer #(
    parameter int FRQ       = 1_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LEN       = 16,
    parameter int GAP_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    output logic [2:0]              octave,
    output logic                    nOn,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(LEN)-1:0]  step
);
    import melody_pkg::*;

    localparam int STEP_W = $clog2(LEN);
    localparam int CYC    = FRQ / TICK_HZ;
    localparam int PW     = (CYC > 1) ? $clog2(CYC) : 1;
    localparam int TMAX   = (GAP_TICKS > 15) ? GAP_TICKS : 15;
    localparam int TW     = $clog2(TMAX + 1);

    state_t          state;
    logic [PW-1:0]   presc;
    logic [TW-1:0]   ticks;
    logic [3:0]      dur;
    logic [7:0]      e0;
    logic [7:0]      en;
    logic [7:0]      load_e;
    logic [STEP_W-1:0] nxt_addr;
    logic            tick_end;
    logic            note_end;
    logic            gap_end;
    logic            melody_over;

    // Entry 0 is read on its own port so start and loop wrap never contend with the look-ahead.
    melody_rom #(.LEN(LEN), .AW(STEP_W)) u_rom0 (.addr('0),      .data(e0));
    melody_rom #(.LEN(LEN), .AW(STEP_W)) u_romn (.addr(nxt_addr), .data(en));

    assign nxt_addr    = step + STEP_W'(1);
    assign tick_end    = (presc == PW'(CYC - 1));
    assign note_end    = tick_end && (ticks == TW'(dur - 4'd1));
    assign gap_end     = tick_end && (ticks == TW'(GAP_TICKS - 1));
    assign melody_over = (step == STEP_W'(LEN - 1)) || (entry_dur(en) == END_MARK);
    assign load_e      = (state == IDLE || melody_over) ? e0 : en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            step   <= '0;
            octave <= 3'd0;
            nOn    <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            presc  <= '0;
            ticks  <= '0;
            dur    <= 4'd0;
        end else begin
            done <= 1'b0;
            if (tick_end) begin
                presc <= '0;
                ticks <= ticks + TW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            if (stop) begin
                state <= IDLE;
                nOn   <= 1'b1;
                busy  <= 1'b0;
                presc <= '0;
                ticks <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        ticks <= '0;
                        if (start) begin
                            step <= '0;
                            if (entry_dur(e0) == END_MARK) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state  <= NOTE;
                                busy   <= 1'b1;
                                octave <= entry_note(load_e);
                                nOn    <= entry_rest(load_e);
                                dur    <= entry_dur(load_e);
                            end
                        end
                    end
                    NOTE: begin
                        if (note_end) begin
                            state <= GAP;
                            nOn   <= 1'b1;
                            presc <= '0;
                            ticks <= '0;
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            presc <= '0;
                            ticks <= '0;
                            if (melody_over) begin
`ifdef MELODY_LOOP_EN
                                done   <= 1'b1;
                                step   <= '0;
                                state  <= NOTE;
                                octave <= entry_note(load_e);
                                nOn    <= entry_rest(load_e);
                                dur    <= entry_dur(load_e);
`else
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
`endif
                            end else begin
                                step   <= nxt_addr;
                                state  <= NOTE;
                                octave <= entry_note(load_e);
                                nOn    <= entry_rest(load_e);
                                dur    <= entry_dur(load_e);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        presc <= '0;
                        ticks <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - table-driven bench for melody_sequencer at 10 clk cycles per tick
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] octave;
    logic       nOn;
    logic       busy;
    logic       done;
    logic [3:0] step;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    melody_sequencer #(
        .FRQ(1000),
        .TICK_HZ(100),
        .LEN(16),
        .GAP_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .octave(octave),
        .nOn(nOn),
        .busy(busy),
        .done(done),
        .step(step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        int         edges;
        logic       n_on;
        logic       busy;
        logic       done;
        logic [2:0] oct;
        logic [3:0] step;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function void add(input logic r, input logic s, input logic p, input int e,
                      input logic n, input logic b, input logic d,
                      input logic [2:0] o, input logic [3:0] st, input string nm);
        vec_t x;
        x.rst = r; x.start = s; x.stop = p; x.edges = e;
        x.n_on = n; x.busy = b; x.done = d; x.oct = o; x.step = st; x.name = nm;
        vecs.push_back(x);
    endfunction

    task automatic apply(input vec_t x);
        rst   = x.rst;
        start = x.start;
        stop  = x.stop;
        repeat (x.edges) begin
            @(posedge clk);
            #1;
            rst   = 1'b0;
            start = 1'b0;
            stop  = 1'b0;
        end
        tests++;
        if ({nOn, busy, done, octave, step} !== {x.n_on, x.busy, x.done, x.oct, x.step}) begin
            fails++;
            $display("FAIL %s: got nOn=%b busy=%b done=%b octave=%0d step=%0d, want nOn=%b busy=%b done=%b octave=%0d step=%0d",
                     x.name, nOn, busy, done, octave, step,
                     x.n_on, x.busy, x.done, x.oct, x.step);
        end
    endtask

    initial begin
        //   rst start stop edges  nOn busy done oct step
        add(1, 0, 0, 2,   1, 0, 0, 0, 0,  "reset");
`ifdef MELODY_LOOP_EN
        add(0, 1, 0, 1,   0, 1, 0, 5, 0,  "loop start");
        add(0, 0, 0, 50,  1, 1, 0, 0, 1,  "step1 gap");
        add(0, 0, 0, 429, 1, 1, 0, 0, 15, "step15 gap last");
        add(0, 0, 0, 1,   0, 1, 1, 5, 0,  "loop wrap");
        add(0, 0, 0, 1,   0, 1, 0, 5, 0,  "loop continues");
        add(0, 0, 1, 1,   1, 0, 0, 5, 0,  "stop loop");
        add(0, 0, 0, 3,   1, 0, 0, 5, 0,  "idle after loop stop");
`else
        add(0, 1, 0, 1,   0, 1, 0, 5, 0,  "note0 entry");
        add(0, 0, 0, 29,  0, 1, 0, 5, 0,  "note0 last");
        add(0, 0, 0, 1,   1, 1, 0, 5, 0,  "gap0 entry");
        add(0, 0, 0, 19,  1, 1, 0, 5, 0,  "gap0 last");
        add(0, 0, 0, 1,   1, 1, 0, 2, 1,  "rest entry");
        add(0, 0, 0, 9,   1, 1, 0, 2, 1,  "rest last");
        add(0, 0, 0, 1,   1, 1, 0, 2, 1,  "gap1 entry");
        add(0, 0, 0, 19,  1, 1, 0, 2, 1,  "gap1 last");
        add(0, 0, 0, 1,   1, 0, 1, 2, 1,  "done pulse");
        add(0, 0, 0, 1,   1, 0, 0, 2, 1,  "idle after done");
        add(0, 1, 1, 1,   1, 0, 0, 2, 1,  "start+stop in idle");
        add(0, 0, 0, 3,   1, 0, 0, 2, 1,  "still idle");
        add(0, 1, 0, 1,   0, 1, 0, 5, 0,  "restart");
        add(0, 0, 0, 4,   0, 1, 0, 5, 0,  "note 4 cycles in");
        add(0, 0, 1, 1,   1, 0, 0, 5, 0,  "stop mid note");
        add(0, 0, 0, 2,   1, 0, 0, 5, 0,  "idle after stop");
        add(0, 1, 0, 1,   0, 1, 0, 5, 0,  "start again");
        add(0, 0, 0, 9,   0, 1, 0, 5, 0,  "note 9 cycles in");
        add(0, 1, 0, 1,   0, 1, 0, 5, 0,  "start while busy");
        add(0, 0, 0, 19,  0, 1, 0, 5, 0,  "note timing kept");
        add(0, 0, 0, 1,   1, 1, 0, 5, 0,  "gap timing kept");
        add(0, 0, 1, 1,   1, 0, 0, 5, 0,  "stop in gap");
        add(0, 1, 0, 1,   0, 1, 0, 5, 0,  "start for rst");
        add(0, 0, 0, 2,   0, 1, 0, 5, 0,  "note before rst");
        add(1, 0, 0, 1,   1, 0, 0, 0, 0,  "rst mid note");
        add(0, 0, 0, 3,   1, 0, 0, 0, 0,  "idle after rst");
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL done pulse count: got %0d, want 1", done_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
